// File: rtl/fan_tach_meter.sv
// Fan tachometer speed meter: synchronizes and deglitches tach_i, counts falling
// edges over a fixed clk_en-tick window, and reports a saturated speed plus a stall flag.
module fan_tach_meter #(
   parameter int ADC_BITWIDTH          = 8,
   parameter int GATE_TICKS            = 1000000,
   parameter int GATE_COUNTER_BITWIDTH = 20,
   parameter int FILTER_TICKS          = 4,
   parameter int STALL_WINDOWS         = 3
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    clk_en_i,
   input  logic                    enable_i,
   input  logic                    tach_i,
   output logic [ADC_BITWIDTH-1:0] value_o,
   output logic                    dataValid_STRB_o,
   output logic                    stall_o
);

   localparam logic [GATE_COUNTER_BITWIDTH-1:0] GATE_LAST = GATE_COUNTER_BITWIDTH'(GATE_TICKS - 1);
   localparam logic [3:0]                       FILT_LAST = 4'(FILTER_TICKS - 1);
   localparam logic [3:0]                       STALL_MAX = 4'(STALL_WINDOWS);
   localparam logic [ADC_BITWIDTH:0]            EDGE_MAX  = '1;
   localparam logic [ADC_BITWIDTH-1:0]          VAL_MAX   = '1;

   logic                             sync1_q, sync2_q;
   logic                             filt_q, filt_d;
   logic [3:0]                       filt_cnt_q, filt_cnt_d;
   logic [ADC_BITWIDTH:0]            edge_cnt_q, edge_cnt_d;
   logic [GATE_COUNTER_BITWIDTH-1:0] gate_q, gate_d;
   logic [3:0]                       stall_cnt_q, stall_cnt_d;
   logic [ADC_BITWIDTH-1:0]          value_q, win_val;
   logic                             strb_q, stall_q;
   logic                             filt_hit, fall, win_end;

   // Synchronizer runs on every clk_i, independent of clk_en_i and enable_i.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= tach_i;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      filt_hit    = (sync2_q != filt_q) && (filt_cnt_q == FILT_LAST);
      filt_cnt_d  = ((sync2_q != filt_q) && !filt_hit) ? filt_cnt_q + 4'd1 : 4'd0;
      filt_d      = filt_hit ? sync2_q : filt_q;
      fall        = filt_hit && !sync2_q;
      edge_cnt_d  = (fall && (edge_cnt_q != EDGE_MAX)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
      win_end     = (gate_q == GATE_LAST);
      gate_d      = win_end ? '0 : gate_q + 1'b1;
      // An edge on the boundary tick is included via edge_cnt_d.
      win_val     = edge_cnt_d[ADC_BITWIDTH] ? VAL_MAX : edge_cnt_d[ADC_BITWIDTH-1:0];
      stall_cnt_d = (win_val != '0)            ? 4'd0 :
                    (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + 4'd1;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         filt_q      <= 1'b1;
         filt_cnt_q  <= '0;
         edge_cnt_q  <= '0;
         gate_q      <= '0;
         stall_cnt_q <= '0;
         value_q     <= '0;
         strb_q      <= 1'b0;
         stall_q     <= 1'b0;
      end else begin
         strb_q  <= 1'b0;
         stall_q <= (stall_cnt_q == STALL_MAX);
         if (clk_en_i) begin
            if (!enable_i) begin
               filt_q      <= 1'b1;
               filt_cnt_q  <= '0;
               edge_cnt_q  <= '0;
               gate_q      <= '0;
               stall_cnt_q <= '0;
            end else begin
               filt_q     <= filt_d;
               filt_cnt_q <= filt_cnt_d;
               gate_q     <= gate_d;
               if (win_end) begin
                  value_q     <= win_val;
                  strb_q      <= 1'b1;
                  edge_cnt_q  <= '0;
                  stall_cnt_q <= stall_cnt_d;
               end else begin
                  edge_cnt_q <= edge_cnt_d;
               end
            end
         end
      end
   end

   assign value_o          = value_q;
   assign dataValid_STRB_o = strb_q;
   assign stall_o          = stall_q;

endmodule

// File: tb/tb_fan_tach_meter.sv
// Directed bench for fan_tach_meter: square wave, glitch rejection, saturation,
// stall detection, enable gating and asynchronous reset.
module tb_fan_tach_meter;

   logic       clk = 1'b0, rstn = 1'b0, clk_en = 1'b1, en = 1'b1;
   logic       tach = 1'b1, tach2 = 1'b1;
   logic [7:0] val, val2;
   logic       strb, strb2, stall, stall2;
   int         n_cmp = 0, n_bad = 0;
   int         mode = 0;  // 0 high, 1 square 5/5, 2 3-clk glitch per 20, 3 6-clk pulse per 20

   always #5 clk = ~clk;

   fan_tach_meter #(.ADC_BITWIDTH(8), .GATE_TICKS(100), .GATE_COUNTER_BITWIDTH(7),
                    .FILTER_TICKS(4), .STALL_WINDOWS(3)) dut (
      .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .enable_i(en), .tach_i(tach),
      .value_o(val), .dataValid_STRB_o(strb), .stall_o(stall));

   fan_tach_meter #(.ADC_BITWIDTH(8), .GATE_TICKS(4000), .GATE_COUNTER_BITWIDTH(12),
                    .FILTER_TICKS(4), .STALL_WINDOWS(3)) dut_sat (
      .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .enable_i(1'b1), .tach_i(tach2),
      .value_o(val2), .dataValid_STRB_o(strb2), .stall_o(stall2));

   // Waveform phase restarts on every mode change, so windows stay aligned.
   initial begin : gen
      int ph;
      int last;
      ph = 0;
      last = -1;
      forever begin
         @(posedge clk);
         #2;
         if (mode != last) begin
            ph = 0;
            last = mode;
         end
         case (mode)
            1:       tach = ((ph % 10) < 5)  ? 1'b0 : 1'b1;
            2:       tach = ((ph % 20) < 3)  ? 1'b0 : 1'b1;
            3:       tach = ((ph % 20) < 6)  ? 1'b0 : 1'b1;
            default: tach = 1'b1;
         endcase
         ph++;
      end
   end

   initial begin : gen2
      int p;
      p = 0;
      forever begin
         @(posedge clk);
         #2;
         tach2 = ((p % 10) < 5) ? 1'b0 : 1'b1;
         p++;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Counts negedges until the selected strobe is seen, bounded.
   task automatic wait_strb(input bit sat, input int bound, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sat ? strb2 : strb) && n < bound);
      if (!(sat ? strb2 : strb)) chk("strobe_timeout", 0, 1);
   endtask

   initial begin : main
      int n;
      int s;
      mode = 1;
      repeat (3) @(negedge clk);
      chk("rst_value", val, 0);
      chk("rst_strb", strb, 0);
      chk("rst_stall", stall, 0);
      rstn = 1'b1;

      wait_strb(0, 200, n);  chk("first_latency", n, 100);
      wait_strb(0, 200, n);  chk("sq_period", n, 100);  chk("sq_value", val, 10);
      @(negedge clk);        chk("strb_width", strb, 0);
      wait_strb(0, 200, n);  chk("sq_value2", val, 10);

      mode = 2;
      wait_strb(0, 200, n);
      wait_strb(0, 200, n);  chk("glitch3_value", val, 0);
      mode = 3;
      wait_strb(0, 200, n);
      wait_strb(0, 200, n);  chk("pulse6_value", val, 5);
      mode = 1;
      wait_strb(0, 200, n);
      wait_strb(0, 200, n);  chk("sq_value3", val, 10);

      repeat (50) @(negedge clk);
      en = 1'b0;
      s = 0;
      repeat (30) begin
         @(negedge clk);
         if (strb) s++;
      end
      chk("gap_strobes", s, 0);
      chk("gap_value", val, 10);
      chk("gap_stall", stall, 0);
      en = 1'b1;
      wait_strb(0, 200, n);  chk("reen_latency", n, 100);  chk("reen_value", val, 10);

      repeat (50) @(negedge clk);
      mode = 0;
      wait_strb(0, 200, n);  chk("stallA_value", val, 5);
      wait_strb(0, 200, n);  chk("stallB_value", val, 0);  chk("stallB_stall", stall, 0);
      wait_strb(0, 200, n);  chk("stallC_stall", stall, 0);
      wait_strb(0, 200, n);  chk("stallD_value", val, 0);  chk("stallD_pre", stall, 0);
      @(negedge clk);        chk("stallD_post", stall, 1);
      mode = 1;
      wait_strb(0, 200, n);  chk("resume_value", val, 10);  chk("resume_pre", stall, 1);
      @(negedge clk);        chk("resume_post", stall, 0);

      repeat (30) @(negedge clk);
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      chk("arst_value", val, 0);
      chk("arst_strb", strb, 0);
      chk("arst_stall", stall, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      wait_strb(0, 200, n);  chk("arst_latency", n, 100);

      wait_strb(1, 4100, n);
      wait_strb(1, 4100, n); chk("sat_period", n, 4000);  chk("sat_value", val2, 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
